axi4_lite_reg_bank: RTL and testbench



---
 rtl/axi4_lite_reg_bank.sv | 125 ++++++++++++
 tb/tb_axi4_lite_reg_bank.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/axi4_lite_reg_bank.sv
// rtl/axi4_lite_reg_bank.sv - DMA control/status/config register bank behind the AXI4-Lite write front-end
// Optional IRQ output and CTRL.IRQ_EN bit enabled by defining DMA_REG_IRQ_EN.
module axi4_lite_reg_bank #(
    parameter int DEPTH     = 4,
    parameter int DATA_SIZE = 32
) (
    input  logic                            clk_i,
    input  logic                            rst_clk_i,
    input  logic [DATA_SIZE-1:0]            register_data_i,
    input  logic [$clog2(DEPTH)-1:0]        register_address_i,
    input  logic [DATA_SIZE/8-1:0]          enable_register_data_i,
    input  logic [$clog2(DEPTH)-1:0]        read_address_i,
    output logic [DATA_SIZE-1:0]            read_data_o,
    output logic                            start_o,
    input  logic                            busy_i,
    input  logic                            done_i,
    input  logic                            error_i,
    output logic [DATA_SIZE*(DEPTH-2)-1:0]  config_o,
    output logic                            irq_o
);

    localparam int AW   = $clog2(DEPTH);
    localparam int NB   = DATA_SIZE / 8;
    localparam int NCFG = DEPTH - 2;

    logic [DATA_SIZE-1:0] cfg_q [NCFG];
    logic [DATA_SIZE-1:0] cfg_d [NCFG];
    logic [DATA_SIZE-1:0] read_data_q, read_data_d;
    logic                 start_q, start_d;
    logic                 done_q, done_d;
    logic                 err_q, err_d;
    logic                 wr_en, ctrl_wr, stat_wr, start_req;

`ifdef DMA_REG_IRQ_EN
    logic irq_en_q, irq_en_d;
    logic irq_q;
`endif

    always_comb begin
        wr_en     = |enable_register_data_i;
        ctrl_wr   = wr_en && (register_address_i == AW'(0)) && enable_register_data_i[0];
        stat_wr   = wr_en && (register_address_i == AW'(1)) && enable_register_data_i[0];
        start_req = ctrl_wr && register_data_i[0];

        // A start request while the engine is busy is dropped and flagged as an error.
        start_d = start_req && !busy_i;
        done_d  = done_i | (done_q & ~(stat_wr & register_data_i[1]));
        err_d   = error_i | (start_req & busy_i) | (err_q & ~(stat_wr & register_data_i[2]));

`ifdef DMA_REG_IRQ_EN
        irq_en_d = ctrl_wr ? register_data_i[1] : irq_en_q;
`endif

        cfg_d = cfg_q;
        for (int k = 0; k < NCFG; k++) begin
            if (wr_en && (register_address_i == AW'(k + 2))) begin
                for (int b = 0; b < NB; b++) begin
                    if (enable_register_data_i[b]) begin
                        cfg_d[k][b*8 +: 8] = register_data_i[b*8 +: 8];
                    end
                end
            end
        end

        // Read mux uses current state, so a same-cycle write is not visible yet.
        read_data_d = '0;
        if (read_address_i == AW'(0)) begin
`ifdef DMA_REG_IRQ_EN
            read_data_d[1] = irq_en_q;
`endif
        end else if (read_address_i == AW'(1)) begin
            read_data_d[0] = busy_i;
            read_data_d[1] = done_q;
            read_data_d[2] = err_q;
        end else begin
            for (int k = 0; k < NCFG; k++) begin
                if (read_address_i == AW'(k + 2)) begin
                    read_data_d = cfg_q[k];
                end
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_clk_i) begin
            for (int k = 0; k < NCFG; k++) begin
                cfg_q[k] <= '0;
            end
            read_data_q <= '0;
            start_q     <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            cfg_q       <= cfg_d;
            read_data_q <= read_data_d;
            start_q     <= start_d;
            done_q      <= done_d;
            err_q       <= err_d;
        end
    end

`ifdef DMA_REG_IRQ_EN
    always_ff @(posedge clk_i) begin
        if (rst_clk_i) begin
            irq_en_q <= 1'b0;
            irq_q    <= 1'b0;
        end else begin
            irq_en_q <= irq_en_d;
            irq_q    <= irq_en_q & (done_q | err_q);
        end
    end

    assign irq_o = irq_q;
`else
    assign irq_o = 1'b0;
`endif

    for (genvar k = 0; k < NCFG; k++) begin : g_cfg_out
        assign config_o[k*DATA_SIZE +: DATA_SIZE] = cfg_q[k];
    end

    assign read_data_o = read_data_q;
    assign start_o     = start_q;

endmodule

// File: tb/tb_axi4_lite_reg_bank.sv
// tb/tb_axi4_lite_reg_bank.sv - scoreboard bench for axi4_lite_reg_bank against a behavioural register model
module tb_axi4_lite_reg_bank;

    localparam int DEPTH = 4;
    localparam int DS    = 32;
    localparam int NB    = DS / 8;
    localparam int NCFG  = DEPTH - 2;

    logic                 clk = 1'b0;
    logic                 rst;
    logic [DS-1:0]        wdata;
    logic [1:0]           waddr;
    logic [NB-1:0]        wbe;
    logic [1:0]           raddr;
    logic [DS-1:0]        rdata;
    logic                 start;
    logic                 busy;
    logic                 done;
    logic                 error;
    logic [DS*NCFG-1:0]   cfg;
    logic                 irq;

    int tests = 0;
    int fails = 0;

    typedef struct {
        logic [DS-1:0]      rd;
        logic               start;
        logic               irq;
        logic [DS*NCFG-1:0] cfg;
    } exp_t;

    exp_t exp_q [$];

    logic [DS-1:0] m_cfg [NCFG];
    logic          m_done, m_err, m_irq_en;

    always #5 clk = ~clk;

    axi4_lite_reg_bank #(.DEPTH(DEPTH), .DATA_SIZE(DS)) dut (
        .clk_i                  (clk),
        .rst_clk_i              (rst),
        .register_data_i        (wdata),
        .register_address_i     (waddr),
        .enable_register_data_i (wbe),
        .read_address_i         (raddr),
        .read_data_o            (rdata),
        .start_o                (start),
        .busy_i                 (busy),
        .done_i                 (done),
        .error_i                (error),
        .config_o               (cfg),
        .irq_o                  (irq)
    );

    function automatic logic [DS-1:0] view(input logic [1:0] a, input logic b);
        logic [DS-1:0] v;
        v = '0;
        case (a)
            2'd0: begin
`ifdef DMA_REG_IRQ_EN
                v[1] = m_irq_en;
`endif
            end
            2'd1: v = {29'b0, m_err, m_done, b};
            default: v = m_cfg[int'(a) - 2];
        endcase
        return v;
    endfunction

    task automatic cyc(input logic r, input logic [1:0] wa, input logic [DS-1:0] wd,
                       input logic [NB-1:0] be, input logic [1:0] ra, input logic b,
                       input logic dn, input logic er);
        exp_t e;
        logic wr, ctrl_w, stat_w;
        @(posedge clk);
        #2;
        rst = r; waddr = wa; wdata = wd; wbe = be; raddr = ra;
        busy = b; done = dn; error = er;
        if (r) begin
            for (int k = 0; k < NCFG; k++) m_cfg[k] = '0;
            m_done = 1'b0; m_err = 1'b0; m_irq_en = 1'b0;
            e.rd = '0; e.start = 1'b0; e.irq = 1'b0; e.cfg = '0;
        end else begin
            e.rd = view(ra, b);
`ifdef DMA_REG_IRQ_EN
            e.irq = m_irq_en && (m_done || m_err);
`else
            e.irq = 1'b0;
`endif
            wr     = (be != '0);
            ctrl_w = wr && (wa == 2'd0) && be[0];
            stat_w = wr && (wa == 2'd1) && be[0];
            e.start = ctrl_w && wd[0] && !b;
`ifdef DMA_REG_IRQ_EN
            if (ctrl_w) m_irq_en = wd[1];
`endif
            m_done = dn || (m_done && !(stat_w && wd[1]));
            m_err  = er || (ctrl_w && wd[0] && b) || (m_err && !(stat_w && wd[2]));
            if (wr && wa >= 2'd2) begin
                for (int i = 0; i < NB; i++) begin
                    if (be[i]) m_cfg[int'(wa) - 2][i*8 +: 8] = wd[i*8 +: 8];
                end
            end
            e.cfg = {m_cfg[1], m_cfg[0]};
        end
        exp_q.push_back(e);
    endtask

    task automatic idle(input logic [1:0] ra, input logic b);
        cyc(1'b0, 2'd0, '0, '0, ra, b, 1'b0, 1'b0);
    endtask

    task automatic wr(input logic [1:0] wa, input logic [DS-1:0] wd, input logic [NB-1:0] be,
                      input logic [1:0] ra, input logic b, input logic dn);
        cyc(1'b0, wa, wd, be, ra, b, dn, 1'b0);
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, req);
        end
    endtask

    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("read_data", 64'(rdata), 64'(e.rd));
                chk("start", 64'(start), 64'(e.start));
                chk("irq", 64'(irq), 64'(e.irq));
                chk("config", 64'(cfg), 64'(e.cfg));
            end
        end
    end

    initial begin
        rst = 1'b1; wdata = '0; waddr = '0; wbe = '0; raddr = '0;
        busy = 1'b0; done = 1'b0; error = 1'b0;
        for (int k = 0; k < NCFG; k++) m_cfg[k] = '0;
        m_done = 1'b0; m_err = 1'b0; m_irq_en = 1'b0;

        cyc(1'b1, 2'd0, '0, '0, 2'd0, 1'b0, 1'b0, 1'b0);
        cyc(1'b1, 2'd0, '0, '0, 2'd1, 1'b0, 1'b0, 1'b0);

        for (int a = 0; a < DEPTH; a++) wr(2'(a), 32'hFFFF_FFFF, 4'hF, 2'd2, 1'b0, 1'b0);
        cyc(1'b1, 2'd0, '0, '0, 2'd0, 1'b0, 1'b0, 1'b0);
        for (int a = 0; a < DEPTH; a++) idle(2'(a), 1'b0);

        wr(2'd2, 32'hAABB_CCDD, 4'hF, 2'd2, 1'b0, 1'b0);
        wr(2'd2, 32'h1122_3344, 4'h5, 2'd2, 1'b0, 1'b0);
        idle(2'd2, 1'b0);
        idle(2'd2, 1'b0);

        wr(2'd0, 32'h1, 4'h1, 2'd0, 1'b0, 1'b0);
        idle(2'd0, 1'b0);
        idle(2'd0, 1'b0);
        wr(2'd0, 32'h1, 4'h1, 2'd1, 1'b1, 1'b0);
        idle(2'd1, 1'b1);
        idle(2'd1, 1'b1);
        wr(2'd1, 32'h4, 4'h1, 2'd1, 1'b0, 1'b0);
        idle(2'd1, 1'b0);

        cyc(1'b0, 2'd0, '0, '0, 2'd1, 1'b0, 1'b1, 1'b0);
        idle(2'd1, 1'b0);
        wr(2'd1, 32'h2, 4'h1, 2'd1, 1'b0, 1'b1);
        idle(2'd1, 1'b0);
        wr(2'd1, 32'h2, 4'h1, 2'd1, 1'b0, 1'b0);
        idle(2'd1, 1'b0);

        wr(2'd3, 32'h1234_5678, 4'hF, 2'd3, 1'b0, 1'b0);
        idle(2'd3, 1'b0);
        idle(2'd3, 1'b0);

        wr(2'd0, 32'h2, 4'h1, 2'd0, 1'b0, 1'b0);
        cyc(1'b0, 2'd0, '0, '0, 2'd1, 1'b0, 1'b0, 1'b1);
        idle(2'd1, 1'b0);
        idle(2'd1, 1'b0);
        wr(2'd1, 32'h4, 4'h1, 2'd1, 1'b0, 1'b0);
        idle(2'd1, 1'b0);
        idle(2'd1, 1'b0);
        wr(2'd0, 32'h2, 4'h1, 2'd0, 1'b0, 1'b0);

        for (int n = 0; n < 600; n++) begin
            cyc(($urandom_range(0, 39) == 0),
                2'($urandom_range(0, 3)),
                $urandom,
                ($urandom_range(0, 1) == 1) ? 4'($urandom_range(0, 15)) : 4'h0,
                2'($urandom_range(0, 3)),
                ($urandom_range(0, 3) == 0),
                ($urandom_range(0, 7) == 0),
                ($urandom_range(0, 7) == 0));
        end
        idle(2'd0, 1'b0);

        for (int i = 0; i < 20 && exp_q.size() > 0; i++) @(posedge clk);
        #3;
        tests++;
        if (exp_q.size() != 0) begin
            fails++;
            $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
